// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM state encoding,
// source-ID sizing helper and default gap length.
package intr_pkg;

    localparam int INTR_ARB_DEF_GAP  = 2;
    localparam int INTR_ARB_DEF_NSRC = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } intr_arb_state_e;

    function automatic int intr_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [intr_id_w(INTR_ARB_DEF_NSRC)-1:0] intr_id_t;

endpackage

// File: rtl/intr_prio_sel.sv
// Combinational source selector: first set bit of req, searching upward from
// ptr and wrapping modulo N_SRC. A zero ptr gives plain lowest-index priority.
module intr_prio_sel
    import intr_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int IDW   = intr_id_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             valid,
    output logic [IDW-1:0]   id
);

    logic [IDW-1:0] idx;

    always_comb begin
        valid = 1'b0;
        id    = '0;
        idx   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            idx = IDW'((int'(ptr) + i) % N_SRC);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/intr_arbiter.sv
// Interrupt arbiter: latches rising edges as pending bits and presents one
// interrupt at a time with ack and a post-ack gap. INTR_ARB_RR_EN selects round-robin.
module intr_arbiter
    import intr_pkg::*;
#(
    parameter int N_SRC      = 8,
    parameter int GAP_CYCLES = INTR_ARB_DEF_GAP
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_SRC-1:0]           i_intr_src,
    input  logic [N_SRC-1:0]           i_intr_en,
    input  logic                       i_ack,
    output logic                       o_intr,
    output logic [intr_id_w(N_SRC)-1:0] o_intr_id,
    output logic [N_SRC-1:0]           o_pending
);

    localparam int IDW = intr_id_w(N_SRC);
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    intr_arb_state_e  state, state_n;
    logic [N_SRC-1:0] pending, pending_w, src_d, rise, clr, eligible;
    logic [IDW-1:0]   id_r, id_n, sel_id, sel_ptr;
    logic [GW-1:0]    gap_cnt, gap_n;
    logic             sel_valid, ack_acc;

    assign rise     = i_intr_src & ~src_d;
    assign clr      = ack_acc ? (N_SRC'(1) << id_r) : '0;
    // Clear first, then set: a fresh event on the acked source is kept.
    assign pending_w = (pending & ~clr) | (rise & i_intr_en);
    assign eligible  = pending & i_intr_en;

    intr_prio_sel #(.N_SRC(N_SRC), .IDW(IDW)) u_sel (
        .req   (eligible),
        .ptr   (sel_ptr),
        .valid (sel_valid),
        .id    (sel_id)
    );

`ifdef INTR_ARB_RR_EN
    logic [IDW-1:0] rr_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            rr_ptr <= '0;
        else if (ack_acc)
            rr_ptr <= (id_r == IDW'(N_SRC - 1)) ? '0 : id_r + 1'b1;
    end

    assign sel_ptr = rr_ptr;
`else
    assign sel_ptr = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            pending <= '0;
            src_d   <= '0;
            id_r    <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_w;
            src_d   <= i_intr_src;
            id_r    <= id_n;
            gap_cnt <= gap_n;
        end
    end

    always_comb begin
        state_n = state;
        id_n    = id_r;
        gap_n   = gap_cnt;
        ack_acc = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    id_n    = sel_id;
                    state_n = ASSERT;
                end
            end
            ASSERT: begin
                // Masking the source after grant does not withdraw the request.
                if (i_ack) begin
                    ack_acc = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_n = GAP;
                        gap_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1))
                    state_n = IDLE;
                else
                    gap_n = gap_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_intr    = (state == ASSERT);
    assign o_intr_id = id_r;
    assign o_pending = pending;

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed bench for intr_arbiter with a timestamp-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_intr_arbiter;

    localparam int N   = 8;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] src = '0;
    logic [7:0] en  = 8'hFF;
    logic       ack = 1'b0;
    logic       o_intr;
    logic [2:0] o_intr_id;
    logic [7:0] o_pending;

    int n_chk  = 0;
    int n_fail = 0;

    intr_arbiter #(.N_SRC(N), .GAP_CYCLES(GAP)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_intr_src (src),
        .i_intr_en  (en),
        .i_ack      (ack),
        .o_intr     (o_intr),
        .o_intr_id  (o_intr_id),
        .o_pending  (o_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a grant is either in progress or the next one may start
    // once the cycle count reaches idle_from.
    typedef struct {
        bit       valid;
        bit [7:0] pend;
        bit [7:0] prev;
        bit       busy;
        int       id;
        int       cyc;
        int       idle_from;
        int       rr;
    } m_t;

    m_t m = '{valid: 0, pend: 0, prev: 0, busy: 0, id: 0, cyc: 0, idle_from: 0, rr: 0};

    function automatic m_t step(m_t s, bit r, bit [7:0] sv, bit [7:0] ev, bit a);
        m_t       n = s;
        bit [7:0] elig;
        bit       got = 0;
        if (r) begin
            n.valid = 1; n.pend = 0; n.prev = 0; n.busy = 0;
            n.id = 0; n.rr = 0; n.idle_from = s.cyc + 1;
        end else begin
            elig = s.pend & ev;
            if (s.busy) begin
                if (a) begin
                    n.pend[s.id] = 1'b0;
                    n.busy       = 0;
                    n.idle_from  = s.cyc + 1 + GAP;
`ifdef INTR_ARB_RR_EN
                    n.rr = (s.id + 1) % N;
`endif
                end
            end else if (s.cyc >= s.idle_from && elig != 0) begin
                for (int k = 0; k < N; k++) begin
                    int j = (s.rr + k) % N;
                    if (!got && elig[j]) begin
                        got = 1; n.busy = 1; n.id = j;
                    end
                end
            end
            n.pend = n.pend | (sv & ~s.prev & ev);
            n.prev = sv;
        end
        n.cyc = s.cyc + 1;
        return n;
    endfunction

    always @(posedge clk) m <= step(m, rst, src, en, ack);

    always @(negedge clk) begin
        if (m.valid) begin
            chk("model_intr", o_intr, m.busy);
            chk("model_id", o_intr_id, m.id);
            chk("model_pending", o_pending, m.pend);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

`ifdef INTR_ARB_RR_EN
    localparam int T2_FIRST = 5, T2_SECOND = 2;
    int exp6[6] = '{0, 1, 7, 0, 1, 7};
`else
    localparam int T2_FIRST = 2, T2_SECOND = 5;
    int exp6[6] = '{0, 0, 0, 0, 0, 0};
`endif

    int got6[6];
    int ng;

    initial begin
        // 1: reset state, single source latency and ack
        tick(); rst = 0;
        chk("reset_intr", o_intr, 0);
        chk("reset_pending", o_pending, 0);
        chk("reset_id", o_intr_id, 0);
        src = 8'h08; tick();
        src = 8'h00;
        chk("t1_pend_t1", o_pending, 8'h08);
        chk("t1_intr_t1", o_intr, 0);
        tick();
        chk("t1_intr_t2", o_intr, 1);
        chk("t1_id", o_intr_id, 3);
        tick(); ack = 1; tick(); ack = 0;
        chk("t1_intr_after_ack", o_intr, 0);
        chk("t1_pend_after_ack", o_pending, 0);

        // 2: simultaneous sources, gap spacing
        tick(3);
        src = 8'h24; tick(); src = 8'h00; tick();
        chk("t2_first_intr", o_intr, 1);
        chk("t2_first_id", o_intr_id, T2_FIRST);
        ack = 1; tick(); ack = 0;
        chk("t2_gap_intr", o_intr, 0);
        chk("t2_id_hold", o_intr_id, T2_FIRST);
        tick(2);
        chk("t2_gap_end_intr", o_intr, 0);
        tick();
        chk("t2_second_intr", o_intr, 1);
        chk("t2_second_id", o_intr_id, T2_SECOND);
        ack = 1; tick(); ack = 0;
        chk("t2_pend_zero", o_pending, 0);

        // 3: masking
        tick(3);
        en = 8'hEF; src = 8'h10; tick(); src = 8'h00; tick();
        chk("t3_masked_pend", o_pending, 0);
        chk("t3_masked_intr", o_intr, 0);
        en = 8'hFF; src = 8'h40; tick();
        src = 8'h00; en = 8'hBF;
        chk("t3_pend6", o_pending, 8'h40);
        tick(3);
        chk("t3_disabled_intr", o_intr, 0);
        chk("t3_disabled_pend", o_pending, 8'h40);
        en = 8'hFF; tick(2);
        chk("t3_reenabled_intr", o_intr, 1);
        chk("t3_reenabled_id", o_intr_id, 6);
        ack = 1; tick(); ack = 0;

        // 4: new event on the acked source in the ack cycle
        tick(3);
        src = 8'h02; tick(); src = 8'h00; tick();
        chk("t4_first_id", o_intr_id, 1);
        ack = 1; src = 8'h02; tick(); ack = 0; src = 8'h00;
        chk("t4_pend_kept", o_pending, 8'h02);
        chk("t4_intr_low", o_intr, 0);
        tick(3);
        chk("t4_second_intr", o_intr, 1);
        chk("t4_second_id", o_intr_id, 1);
        ack = 1; tick(); ack = 0;

        // 5: reset mid-handshake
        tick(3);
        src = 8'h08; tick(); src = 8'h00; tick();
        src = 8'h04; tick(); src = 8'h00;
        chk("t5_pre_intr", o_intr, 1);
        chk("t5_pre_id", o_intr_id, 3);
        chk("t5_pre_pend", o_pending, 8'h0C);
        rst = 1; tick(); rst = 0;
        chk("t5_rst_intr", o_intr, 0);
        chk("t5_rst_pend", o_pending, 0);
        ack = 1; tick(); ack = 0;
        chk("t5_ack_ignored_intr", o_intr, 0);
        chk("t5_ack_ignored_pend", o_pending, 0);

        // 6: sources 0,1,7 re-pending continuously
        rst = 1; tick(); rst = 0;
        ng = 0;
        for (int c = 0; c < 300 && ng < 6; c++) begin
            src = src ^ 8'h83;
            if (o_intr && !ack) begin
                got6[ng] = o_intr_id;
                ng++;
                ack = 1;
            end else begin
                ack = 0;
            end
            tick();
        end
        ack = 0; src = 8'h00;
        chk("t6_grant_count", ng, 6);
        for (int i = 0; i < 6; i++)
            if (i < ng) chk($sformatf("t6_grant%0d", i), got6[i], exp6[i]);

        tick(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
